// File: rtl/fpu_sched_if.sv
// -----------------------------------------------------------------------------
// fpu_sched_if
//
// Purpose: Groups the core-side request and response channels of the FPU
//          scheduler. Requests travel as flattened per-requester vectors;
//          requester i occupies slice i of each field.
//
// Signals:
//   req_valid  [N_REQ]     per-requester request valid            (master -> slave)
//   req_ready  [N_REQ]     per-requester accept, at most one high (slave -> master)
//   req_op     [3*N_REQ]   FPU op, requester i at [3i+2:3i]       (master -> slave)
//   req_rmode  [2*N_REQ]   rounding mode per requester            (master -> slave)
//   req_opa    [32*N_REQ]  operand A per requester                (master -> slave)
//   req_opb    [32*N_REQ]  operand B per requester                (master -> slave)
//   resp_valid             result available                       (slave -> master)
//   resp_ready             consumer accepts result                (master -> slave)
//   resp_id    [ID_W]      index of the requester that issued the op
//   resp_out   [32]        FPU result
//   resp_flags [8]         {snan, qnan, inf, ine, overflow, underflow,
//                           div_by_zero, zero}
//
// Modports: master = core-side issue logic, slave = fpu_sched.
// -----------------------------------------------------------------------------
interface fpu_sched_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 3
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [3*N_REQ-1:0]  req_op;
   logic [2*N_REQ-1:0]  req_rmode;
   logic [32*N_REQ-1:0] req_opa;
   logic [32*N_REQ-1:0] req_opb;

   logic                resp_valid;
   logic                resp_ready;
   logic [ID_W-1:0]     resp_id;
   logic [31:0]         resp_out;
   logic [7:0]          resp_flags;

   modport master (
      output req_valid, req_op, req_rmode, req_opa, req_opb, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_out, resp_flags
   );

   modport slave (
      input  req_valid, req_op, req_rmode, req_opa, req_opb, resp_ready,
      output req_ready, resp_valid, resp_id, resp_out, resp_flags
   );
endinterface

// File: rtl/fpu_sched.sv
// -----------------------------------------------------------------------------
// fpu_sched
//
// Purpose: Shares a single fpu instance among N_REQ requesters. One request is
//          granted at a time; its op, rounding mode and operands are registered
//          onto the FPU inputs and held for the op's fixed latency, then the
//          FPU result and flags are captured and returned on a tagged response
//          channel. Only one op is ever in flight.
//
// Configuration:
//   FPU_SCHED_RR_EN  defined   -> round-robin arbitration (pointer advances to
//                                 grant+1 on every handshake)
//                    undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   bus         fpu_sched_if.slave: request valid/ready, per-requester
//               op/rmode/opa/opb, response valid/ready/id/out/flags
//   busy        high whenever the scheduler is not idle
//   fpu_rmode   registered rounding mode to the FPU
//   fpu_op      registered op to the FPU
//   fpu_opa     registered operand A to the FPU
//   fpu_opb     registered operand B to the FPU
//   fpu_out     FPU result
//   fpu_flags   FPU exception flags, same order as resp_flags
// -----------------------------------------------------------------------------
module fpu_sched #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 3,
   parameter int LAT_ADD = 4,
   parameter int LAT_DIV = 28
) (
   input  logic        clk,
   input  logic        rst_n,
   fpu_sched_if.slave  bus,
   output logic        busy,
   output logic [1:0]  fpu_rmode,
   output logic [2:0]  fpu_op,
   output logic [31:0] fpu_opa,
   output logic [31:0] fpu_opb,
   input  logic [31:0] fpu_out,
   input  logic [7:0]  fpu_flags
);

   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [5:0] CNT_ADD = 6'(LAT_ADD);
   localparam logic [5:0] CNT_DIV = 6'(LAT_DIV);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Latency countdown; the FPU output is sampled when it reaches 1.
   logic [5:0]      cnt;

   logic            grant_vld;
   logic [ID_W-1:0] grant_idx;
   logic [N_REQ-1:0] req_ready_c;
   logic            handshake;

   logic [2:0]      sel_op;
   logic [1:0]      sel_rmode;
   logic [31:0]     sel_opa;
   logic [31:0]     sel_opb;

   logic [ID_W-1:0] resp_id_q;
   logic [31:0]     resp_out_q;
   logic [7:0]      resp_flags_q;

`ifdef FPU_SCHED_RR_EN
   logic [ID_W-1:0] rr_ptr;
`endif

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      // Descending scan: the last hit is the lowest set index.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(k);
         end
      end
`ifdef FPU_SCHED_RR_EN
      // Prefer the lowest valid index at or above the pointer; if none exists
      // the search wraps and the lowest valid index found above stands.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k] && (ID_W'(k) >= rr_ptr)) begin
            grant_idx = ID_W'(k);
         end
      end
`endif
   end

   // Operand mux of the winning requester (constant slices only).
   always_comb begin
      sel_op    = '0;
      sel_rmode = '0;
      sel_opa   = '0;
      sel_opb   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (ID_W'(k) == grant_idx) begin
            sel_op    = bus.req_op[3*k +: 3];
            sel_rmode = bus.req_rmode[2*k +: 2];
            sel_opa   = bus.req_opa[32*k +: 32];
            sel_opb   = bus.req_opb[32*k +: 32];
         end
      end
   end

   // One-hot accept; forced low while reset is asserted.
   always_comb begin
      req_ready_c = '0;
      if (rst_n && (state == IDLE) && grant_vld) begin
         for (int k = 0; k < N_REQ; k++) begin
            req_ready_c[k] = (ID_W'(k) == grant_idx);
         end
      end
   end

   assign handshake = rst_n && (state == IDLE) && grant_vld;

   // --------------------------------------------------------------------------
   // Control FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 6'd1) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FPU_SCHED_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (handshake) begin
         rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
`endif

   // --------------------------------------------------------------------------
   // FPU input registers, latency counter and response capture
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt          <= '0;
         fpu_op       <= '0;
         fpu_rmode    <= '0;
         fpu_opa      <= '0;
         fpu_opb      <= '0;
         resp_id_q    <= '0;
         resp_out_q   <= '0;
         resp_flags_q <= '0;
      end else if (handshake) begin
         fpu_op    <= sel_op;
         fpu_rmode <= sel_rmode;
         fpu_opa   <= sel_opa;
         fpu_opb   <= sel_opb;
         resp_id_q <= grant_idx;
         cnt       <= (sel_op == OP_DIV) ? CNT_DIV : CNT_ADD;
      end else if (state == WAIT) begin
         cnt <= cnt - 6'd1;
         if (cnt == 6'd1) begin
            resp_out_q   <= fpu_out;
            resp_flags_q <= fpu_flags;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_out   = resp_out_q;
   assign bus.resp_flags = resp_flags_q;
   assign busy           = (state != IDLE);

   a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready_c));

endmodule

// File: tb/tb_fpu_sched.sv
// -----------------------------------------------------------------------------
// tb_fpu_sched
//
// Directed bench for fpu_sched. A small FPU stand-in returns hand-computed
// results for the operand pairs used here, but only once the inputs have been
// stable for the op's latency; before that it drives a junk pattern.
// -----------------------------------------------------------------------------
module tb_fpu_sched;

   localparam int N_REQ   = 4;
   localparam int ID_W    = 3;
   localparam int LAT_ADD = 4;
   localparam int LAT_DIV = 28;

   localparam logic [31:0] F24   = 32'h41C00000;
   localparam logic [31:0] F4    = 32'h40800000;
   localparam logic [31:0] F28   = 32'h41E00000;
   localparam logic [31:0] F20   = 32'h41A00000;
   localparam logic [31:0] F6    = 32'h40C00000;
   localparam logic [31:0] F_INF = 32'h7F800000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N_REQ-1:0]    req_valid  = '0;
   logic [3*N_REQ-1:0]  req_op     = '0;
   logic [2*N_REQ-1:0]  req_rmode  = '0;
   logic [32*N_REQ-1:0] req_opa    = '0;
   logic [32*N_REQ-1:0] req_opb    = '0;
   logic                resp_ready = 1'b0;

   logic        busy;
   logic [1:0]  fpu_rmode;
   logic [2:0]  fpu_op;
   logic [31:0] fpu_opa;
   logic [31:0] fpu_opb;
   logic [31:0] fpu_out;
   logic [7:0]  fpu_flags;

   int n_chk = 0;
   int n_err = 0;

   fpu_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus_if ();

   assign bus_if.req_valid  = req_valid;
   assign bus_if.req_op     = req_op;
   assign bus_if.req_rmode  = req_rmode;
   assign bus_if.req_opa    = req_opa;
   assign bus_if.req_opb    = req_opb;
   assign bus_if.resp_ready = resp_ready;

   fpu_sched #(
      .N_REQ  (N_REQ),
      .ID_W   (ID_W),
      .LAT_ADD(LAT_ADD),
      .LAT_DIV(LAT_DIV)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus_if),
      .busy     (busy),
      .fpu_rmode(fpu_rmode),
      .fpu_op   (fpu_op),
      .fpu_opa  (fpu_opa),
      .fpu_opb  (fpu_opb),
      .fpu_out  (fpu_out),
      .fpu_flags(fpu_flags)
   );

   // FPU stand-in: {flags, result} for the known operand pairs.
   function automatic logic [39:0] fpu_ref(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      fpu_ref = {8'hA5, 32'hDEADBEEF};
      if (a == F24 && b == F4) begin
         if (op == 3'd0) fpu_ref = {8'h00, F28};
         if (op == 3'd1) fpu_ref = {8'h00, F20};
         if (op == 3'd3) fpu_ref = {8'h00, F6};
      end else if (op == 3'd3 && a == F24 && b == 32'h0) begin
         fpu_ref = {8'h22, F_INF};   // inf + div_by_zero
      end
   endfunction

   logic [68:0] prev_in = '0;
   int          age     = 0;
   logic [39:0] fpu_res;
   int          lat_need;

   always @(negedge clk) begin
      if ({fpu_rmode, fpu_op, fpu_opa, fpu_opb} != prev_in) age <= 0;
      else if (age < 1000) age <= age + 1;
      prev_in <= {fpu_rmode, fpu_op, fpu_opa, fpu_opb};
   end

   always_comb begin
      fpu_res  = fpu_ref(fpu_op, fpu_opa, fpu_opb);
      lat_need = (fpu_op == 3'd3) ? LAT_DIV : LAT_ADD;
      if (age >= lat_need - 1) {fpu_flags, fpu_out} = fpu_res;
      else                     {fpu_flags, fpu_out} = {8'h5A, 32'hBAADF00D};
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      while (!bus_if.resp_valid && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [1:0] rm,
                          input logic [31:0] a, input logic [31:0] b);
      req_op[3*i +: 3]     = op;
      req_rmode[2*i +: 2]  = rm;
      req_opa[32*i +: 32]  = a;
      req_opb[32*i +: 32]  = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // Issue one op from requester i with resp_ready high and check the result.
   task automatic run_op(input string tag, input int i, input logic [2:0] op,
                         input logic [1:0] rm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input logic [7:0] exp_flags,
                         input int lat);
      int n;
      set_req(i, op, rm, a, b);
      req_valid[i] = 1'b1;
      resp_ready   = 1'b1;
      #1;
      check_val({tag, "_ready"}, 64'(bus_if.req_ready), 64'(1 << i));
      step();
      req_valid[i] = 1'b0;
      check_val({tag, "_fpu_in"}, 64'({fpu_op, fpu_rmode, fpu_opa}), 64'({op, rm, a}));
      check_val({tag, "_fpu_opb"}, 64'(fpu_opb), 64'(b));
      check_val({tag, "_busy"}, 64'(busy), 64'(1));
      wait_resp(n);
      check_val({tag, "_lat"}, 64'(n), 64'(lat));
      check_val({tag, "_id"}, 64'(bus_if.resp_id), 64'(i));
      check_val({tag, "_out"}, 64'(bus_if.resp_out), 64'(exp_out));
      check_val({tag, "_flags"}, 64'(bus_if.resp_flags), 64'(exp_flags));
      step();
      check_val({tag, "_idle"}, 64'({busy, bus_if.resp_valid}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      int g;
      int seen;
      int exp_g;

      // Reset: all requesters asserting, nothing may be accepted.
      req_valid = '1;
      repeat (3) step();
      check_val("rst_ready", 64'(bus_if.req_ready), 64'(0));
      check_val("rst_resp", 64'({bus_if.resp_valid, busy, bus_if.resp_id,
                                 bus_if.resp_out, bus_if.resp_flags}), 64'(0));
      check_val("rst_fpu_in", 64'({fpu_op, fpu_rmode, fpu_opa}), 64'(0));
      check_val("rst_fpu_opb", 64'(fpu_opb), 64'(0));
      req_valid = '0;
      rst_n     = 1'b1;
      step();

      run_op("add",   0, 3'd0, 2'd2, F24, F4,    F28,   8'h00, LAT_ADD);
      run_op("div",   2, 3'd3, 2'd0, F24, F4,    F6,    8'h00, LAT_DIV);
      run_op("div0",  1, 3'd3, 2'd1, F24, 32'h0, F_INF, 8'h22, LAT_DIV);

      // Backpressure: hold the response for 20 cycles with another request pending.
      set_req(3, 3'd0, 2'd0, F24, F4);
      req_valid[3] = 1'b1;
      resp_ready   = 1'b0;
      #1;
      step();
      req_valid[3] = 1'b0;
      wait_resp(n);
      check_val("bp_lat", 64'(n), 64'(LAT_ADD));
      set_req(0, 3'd0, 2'd0, F24, F4);
      req_valid[0] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         check_val("bp_hold", 64'({bus_if.resp_valid, busy, bus_if.req_ready, bus_if.resp_id,
                                   bus_if.resp_out, bus_if.resp_flags}),
                   64'({1'b1, 1'b1, 4'b0000, 3'd3, F28, 8'h00}));
         step();
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check_val("bp_regrant", 64'({busy, bus_if.req_ready}), 64'({1'b0, 4'b0001}));
      step();
      req_valid[0] = 1'b0;
      check_val("bp_busy", 64'(busy), 64'(1));
      resp_ready = 1'b1;
      wait_resp(n);
      check_val("bp_lat2", 64'(n), 64'(LAT_ADD));
      check_val("bp_id2", 64'({bus_if.resp_id, bus_if.resp_out}), 64'({3'd0, F28}));
      step();

      // Reset in the middle of a divide.
      set_req(1, 3'd3, 2'd0, F24, F4);
      req_valid[1] = 1'b1;
      #1;
      step();
      req_valid[1] = 1'b0;
      repeat (10) step();
      check_val("mid_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      set_req(2, 3'd0, 2'd0, F24, F4);
      req_valid[2] = 1'b1;
      step();
      #1;
      check_val("mid_rst_ready", 64'(bus_if.req_ready), 64'(0));
      check_val("mid_rst_resp", 64'({bus_if.resp_valid, busy, bus_if.resp_id,
                                     bus_if.resp_out, bus_if.resp_flags}), 64'(0));
      check_val("mid_rst_fpu_in", 64'({fpu_op, fpu_rmode, fpu_opa}), 64'(0));
      check_val("mid_rst_fpu_opb", 64'(fpu_opb), 64'(0));
      req_valid[2] = 1'b0;
      rst_n        = 1'b1;
      seen = 0;
      repeat (40) begin
         step();
         if (bus_if.resp_valid || busy) seen++;
      end
      check_val("mid_stale", 64'(seen), 64'(0));
      run_op("sub", 0, 3'd1, 2'd0, F24, F4, F20, 8'h00, LAT_ADD);

      // Contention: every requester valid, resp_ready tied high.
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_req(i, 3'd0, 2'd0, F24, F4);
      req_valid  = '1;
      resp_ready = 1'b1;
      #1;
      for (int gi = 0; gi < 5; gi++) begin
         n = 0;
         while (bus_if.req_ready == '0 && n < 100) begin
            step();
            n++;
         end
         check_val("cont_onehot", 64'($countones(bus_if.req_ready)), 64'(1));
         g = 0;
         for (int k = 0; k < N_REQ; k++) if (bus_if.req_ready[k]) g = k;
`ifdef FPU_SCHED_RR_EN
         exp_g = gi % N_REQ;
`else
         exp_g = 0;
`endif
         check_val("cont_grant", 64'(g), 64'(exp_g));
         n = 0;
         do begin
            step();
            n++;
         end while (!bus_if.resp_valid && n < 100);
         check_val("cont_lat", 64'(n), 64'(LAT_ADD + 1));
         check_val("cont_id", 64'({bus_if.resp_id, bus_if.resp_out}), 64'({ID_W'(exp_g), F28}));
         step();
      end
      req_valid = '0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
